// File: rtl/nes_fb_scaler.sv
// NES frame-buffer scaler: stores a 256x240 RGB332 picture and shows it 2x-scaled,
// horizontally centred in a 640x480 VGA raster, with syncs delayed to match the colour pipeline.
module nes_fb_scaler #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned H_OFFSET   = 64,
    parameter logic [7:0]  BORDER_RGB = 8'h00
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic [9:0] x_in,
    input  logic [9:0] y_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       pix_we,
    input  logic [7:0] pix_x,
    input  logic [7:0] pix_y,
    input  logic [7:0] pix_rgb,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       vblank,
    output logic       frame_tick
);

    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] H_OFF     = 10'(H_OFFSET);
    localparam logic [9:0] H_PIC_END = 10'(H_OFFSET + 512);

    logic [7:0]  mem [0:61439];

    logic        act_d;
    logic        pic_d;
    logic        vb_d;
    logic [15:0] rdAddr_d;
    logic [7:0]  colour_d;

    logic        act_q;
    logic        pic_q;
    logic        hs1_q;
    logic        vs1_q;
    logic        vb1_q;
    logic [7:0]  ramData_q;

    logic [7:0]  colour_q;
    logic        hs2_q;
    logic        vs2_q;
    logic        vb2_q;
    logic        tick_q;

    // Address is forced to zero outside the picture so no out-of-range read can occur.
    always_comb begin
        act_d    = (x_in < H_ACT) && (y_in < V_ACT);
        pic_d    = act_d && (x_in >= H_OFF) && (x_in < H_PIC_END);
        vb_d     = !(y_in < V_ACT);
        rdAddr_d = '0;
        if (pic_d) begin
            rdAddr_d = {y_in[8:1], 8'((x_in - H_OFF) >> 1)};
        end
    end

    // Read samples the old word when the same address is written this edge (read-first).
    always_ff @(posedge dclk) begin
        if (pix_we && (pix_y < 8'd240)) begin
            mem[{pix_y, pix_x}] <= pix_rgb;
        end
        ramData_q <= mem[rdAddr_d];
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            act_q <= 1'b0;
            pic_q <= 1'b0;
            hs1_q <= 1'b1;
            vs1_q <= 1'b1;
            vb1_q <= 1'b1;
        end else begin
            act_q <= act_d;
            pic_q <= pic_d;
            hs1_q <= hsync_in;
            vs1_q <= vsync_in;
            vb1_q <= vb_d;
        end
    end

    always_comb begin
        colour_d = 8'h00;
        if (pic_q) begin
            colour_d = ramData_q;
        end else if (act_q) begin
            colour_d = BORDER_RGB;
        end
    end

    // Tick is computed from the value about to enter vb2_q so it lines up with vblank's rise.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            colour_q <= 8'h00;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
            vb2_q    <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            colour_q <= colour_d;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            vb2_q    <= vb1_q;
            tick_q   <= vb1_q & ~vb2_q;
        end
    end

    assign red        = colour_q[7:5];
    assign green      = colour_q[4:2];
    assign blue       = colour_q[1:0];
    assign hsync_out  = hs2_q;
    assign vsync_out  = vs2_q;
    assign vblank     = vb2_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_nes_fb_scaler.sv
// Directed bench for nes_fb_scaler: scaling, border, blanking, sync/vblank alignment and reset.
module tb_nes_fb_scaler;

    logic       dclk;
    logic       clr;
    logic [9:0] x_in;
    logic [9:0] y_in;
    logic       hsync_in;
    logic       vsync_in;
    logic       pix_we;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic [7:0] pix_rgb;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
    logic       hsync_out;
    logic       vsync_out;
    logic       vblank;
    logic       frame_tick;

    int checkCount;
    int errorCount;

    logic [9:0] vecX [6];
    logic [7:0] vecE [6];

    nes_fb_scaler #(
        .H_ACTIVE  (640),
        .V_ACTIVE  (480),
        .H_OFFSET  (64),
        .BORDER_RGB(8'h03)
    ) dut (
        .dclk      (dclk),
        .clr       (clr),
        .x_in      (x_in),
        .y_in      (y_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .pix_we    (pix_we),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_rgb   (pix_rgb),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .vblank    (vblank),
        .frame_tick(frame_tick)
    );

    initial dclk = 1'b0;
    always #20 dclk = ~dclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkColour(input string tag, input logic [7:0] expected);
        checkOutput(tag, {24'd0, red, green, blue}, {24'd0, expected});
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic hs, input logic vs);
        @(negedge dclk);
        x_in     = x;
        y_in     = y;
        hsync_in = hs;
        vsync_in = vs;
    endtask

    task automatic tickEdge();
        @(posedge dclk);
        #1;
    endtask

    task automatic writePixel(input logic [7:0] x, input logic [7:0] y, input logic [7:0] rgb);
        @(negedge dclk);
        pix_we  = 1'b1;
        pix_x   = x;
        pix_y   = y;
        pix_rgb = rgb;
        tickEdge();
        pix_we  = 1'b0;
    endtask

    // Streams vecX on one line, one pixel per cycle; each colour appears two edges after its input.
    task automatic runVectors(input string tag, input logic [9:0] y);
        for (int i = 0; i <= 6; i++) begin
            applyStimulus((i < 6) ? vecX[i] : 10'd900, y, 1'b1, 1'b1);
            tickEdge();
            if (i >= 1) checkColour(tag, vecE[i-1]);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        clr      = 1'b1;
        x_in     = 10'd900;
        y_in     = 10'd1000;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        pix_we   = 1'b0;
        pix_x    = 8'd0;
        pix_y    = 8'd0;
        pix_rgb  = 8'd0;

        #5;
        checkColour("reset_rgb", 8'h00);
        checkOutput("reset_hsync", {31'd0, hsync_out}, 32'd1);
        checkOutput("reset_vsync", {31'd0, vsync_out}, 32'd1);
        checkOutput("reset_vblank", {31'd0, vblank}, 32'd1);
        checkOutput("reset_tick", {31'd0, frame_tick}, 32'd0);
        @(negedge dclk);
        clr = 1'b0;

        writePixel(8'd0, 8'd0, 8'hE0);
        writePixel(8'd1, 8'd0, 8'h1C);
        writePixel(8'd0, 8'd1, 8'h92);
        writePixel(8'd1, 8'd1, 8'h49);

        vecX = '{10'd63, 10'd64, 10'd65, 10'd66, 10'd67, 10'd10};
        vecE = '{8'h03, 8'hE0, 8'hE0, 8'h1C, 8'h1C, 8'h03};
        runVectors("t1_line0", 10'd0);
        runVectors("t2_line1", 10'd1);
        vecE = '{8'h03, 8'h92, 8'h92, 8'h49, 8'h49, 8'h03};
        runVectors("t2_line2", 10'd2);
        runVectors("t2_line3", 10'd3);

        vecX = '{10'd10, 10'd576, 10'd900, 10'd639, 10'd640, 10'd63};
        vecE = '{8'h03, 8'h03, 8'h00, 8'h03, 8'h00, 8'h03};
        runVectors("t3_border", 10'd100);
        vecX = '{10'd10, 10'd64, 10'd300, 10'd576, 10'd65, 10'd63};
        vecE = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        runVectors("t3_vblank1000", 10'd1000);
        runVectors("t3_vblank480", 10'd480);

        writePixel(8'd0, 8'd240, 8'hFF);
        vecX = '{10'd63, 10'd64, 10'd65, 10'd66, 10'd67, 10'd10};
        vecE = '{8'h03, 8'hE0, 8'hE0, 8'h1C, 8'h1C, 8'h03};
        runVectors("t4_dropwrite", 10'd0);

        // Same-cycle read and write of (0,0): old data first, new data on the next read.
        applyStimulus(10'd64, 10'd0, 1'b1, 1'b1);
        pix_we = 1'b1; pix_x = 8'd0; pix_y = 8'd0; pix_rgb = 8'h1F;
        tickEdge();
        pix_we = 1'b0;
        applyStimulus(10'd65, 10'd0, 1'b1, 1'b1);
        tickEdge();
        checkColour("readfirst_old", 8'hE0);
        applyStimulus(10'd900, 10'd0, 1'b1, 1'b1);
        tickEdge();
        checkColour("readfirst_new", 8'h1F);
        writePixel(8'd0, 8'd0, 8'hE0);

        applyStimulus(10'd900, 10'd100, 1'b0, 1'b1);
        tickEdge();
        checkOutput("hsync_d0", {31'd0, hsync_out}, 32'd1);
        applyStimulus(10'd900, 10'd100, 1'b1, 1'b0);
        tickEdge();
        checkOutput("hsync_d1", {31'd0, hsync_out}, 32'd0);
        checkOutput("vsync_d0", {31'd0, vsync_out}, 32'd1);
        applyStimulus(10'd900, 10'd100, 1'b1, 1'b1);
        tickEdge();
        checkOutput("hsync_d2", {31'd0, hsync_out}, 32'd1);
        checkOutput("vsync_d1", {31'd0, vsync_out}, 32'd0);
        applyStimulus(10'd900, 10'd100, 1'b1, 1'b1);
        tickEdge();
        checkOutput("vsync_d2", {31'd0, vsync_out}, 32'd1);

        applyStimulus(10'd0, 10'd479, 1'b1, 1'b1);
        tickEdge();
        applyStimulus(10'd0, 10'd479, 1'b1, 1'b1);
        tickEdge();
        checkOutput("vblank_479", {31'd0, vblank}, 32'd0);
        checkOutput("tick_479", {31'd0, frame_tick}, 32'd0);
        applyStimulus(10'd0, 10'd480, 1'b1, 1'b1);
        tickEdge();
        checkOutput("vblank_e1", {31'd0, vblank}, 32'd0);
        checkOutput("tick_e1", {31'd0, frame_tick}, 32'd0);
        applyStimulus(10'd0, 10'd480, 1'b1, 1'b1);
        tickEdge();
        checkOutput("vblank_e2", {31'd0, vblank}, 32'd1);
        checkOutput("tick_e2", {31'd0, frame_tick}, 32'd1);
        applyStimulus(10'd0, 10'd481, 1'b1, 1'b1);
        tickEdge();
        checkOutput("vblank_e3", {31'd0, vblank}, 32'd1);
        checkOutput("tick_e3", {31'd0, frame_tick}, 32'd0);

        // Mid-line reset with syncs active so the reset values are distinguishable.
        applyStimulus(10'd64, 10'd0, 1'b0, 1'b0);
        tickEdge();
        applyStimulus(10'd64, 10'd0, 1'b0, 1'b0);
        tickEdge();
        checkColour("pre_reset_rgb", 8'hE0);
        checkOutput("pre_reset_vblank", {31'd0, vblank}, 32'd0);
        @(negedge dclk);
        clr = 1'b1;
        #1;
        checkColour("clr_rgb", 8'h00);
        checkOutput("clr_hsync", {31'd0, hsync_out}, 32'd1);
        checkOutput("clr_vsync", {31'd0, vsync_out}, 32'd1);
        checkOutput("clr_vblank", {31'd0, vblank}, 32'd1);
        applyStimulus(10'd66, 10'd0, 1'b1, 1'b1);
        clr = 1'b0;
        tickEdge();
        checkColour("post_clr_e1", 8'h00);
        applyStimulus(10'd900, 10'd0, 1'b1, 1'b1);
        tickEdge();
        checkColour("post_clr_e2", 8'h1C);
        checkOutput("post_clr_vblank", {31'd0, vblank}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
